psram_responder: RTL and testbench

- Synthesizable responder model of the quad-SPI PSRAM device, i.e. the memory end of the PSRAM controller's mem_ce / mem_clk / mem_sio interface.
- Runs on the fast system clock and oversamples the controller's mem_clk and mem_ce, so the bench and on-board loopback tests can exercise the controller without a physical device.
- Decodes RSTEN, RST, enter-QPI, exit-QPI, quad write and quad fast read; stores data in a small internal byte array.

---
 rtl/psram_pkg.sv | 13 +
 rtl/psram_edge_sync.sv | 33 +++
 rtl/psram_responder.sv | 152 +++++++++++++++
 tb/tb_psram_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: opcodes, FSM encoding and address width shared by the PSRAM controller and responder.
package psram_pkg;
   localparam int ADDR_W = 24;
   localparam logic [7:0] CMD_RSTEN  = 8'h66;
   localparam logic [7:0] CMD_RST    = 8'h99;
   localparam logic [7:0] CMD_QPI_EN = 8'h35;
   localparam logic [7:0] CMD_QPI_EX = 8'hF5;
   localparam logic [7:0] CMD_QWRITE = 8'h38;
   localparam logic [7:0] CMD_QREAD  = 8'hEB;
   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_WAIT, ST_WDATA, ST_RDATA, ST_IGNORE
   } state_e;
endpackage

// File: rtl/psram_edge_sync.sv
// psram_edge_sync: synchronizes mem_clk/mem_ce into clk and produces single-cycle edge pulses.
module psram_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_clk,
   input  logic mem_ce,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ce_sync,
   output logic ce_fall
);
   logic [SYNC_STAGES-1:0] clk_sync_q, ce_sync_q;
   logic                   clk_prev_q, ce_prev_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q <= '0;
         ce_sync_q  <= '1;
         clk_prev_q <= 1'b0;
         ce_prev_q  <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], mem_clk};
         ce_sync_q  <= {ce_sync_q[SYNC_STAGES-2:0], mem_ce};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         ce_prev_q  <= ce_sync_q[SYNC_STAGES-1];
      end
   end
   assign sclk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
   assign sclk_fall = ~clk_sync_q[SYNC_STAGES-1] & clk_prev_q;
   assign ce_sync   = ce_sync_q[SYNC_STAGES-1];
   assign ce_fall   = ~ce_sync_q[SYNC_STAGES-1] & ce_prev_q;
endmodule

// File: rtl/psram_responder.sv
// psram_responder: quad-SPI PSRAM device model driven by an oversampled mem_clk/mem_ce,
// backed by a small byte array.
module psram_responder
   import psram_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_CYCLES = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_ce,
   input  logic       mem_clk,
   inout  wire  [3:0] mem_sio,
   output logic       qpi_mode,
   output logic       cmd_valid,
   output logic [7:0] last_cmd,
   output logic       error
);
   logic sclk_rise, sclk_fall, ce_sync, ce_fall;
   psram_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .mem_clk(mem_clk), .mem_ce(mem_ce),
      .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .ce_sync(ce_sync), .ce_fall(ce_fall)
   );
   state_e            state_q, state_d;
   logic [7:0]        sh_q, sh_d, cnt_q, cnt_d, last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        hi_q, hi_d, dout_q, dout_d;
   logic              wr_q, wr_d, ph_q, ph_d, oe_q, oe_d, qpi_q, qpi_d;
   logic              cv_q, cv_d, err_q, err_d, armed_q, armed_d, we;
   logic [7:0]        mem [2**ADDR_BITS];
   logic [7:0]        cmd, rd_byte;
   assign cmd     = qpi_q ? {sh_q[3:0], mem_sio} : {sh_q[6:0], mem_sio[0]};
   assign rd_byte = mem[addr_q[ADDR_BITS-1:0]];
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      dout_d  = dout_q;
      wr_d    = wr_q;
      ph_d    = ph_q;
      oe_d    = oe_q;
      qpi_d   = qpi_q;
      cv_d    = 1'b0;
      err_d   = err_q;
      armed_d = armed_q;
      we      = 1'b0;
      if (ce_sync) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (ce_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
            ST_CMD: if (sclk_rise) begin
               sh_d  = cmd;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == (qpi_q ? 8'd1 : 8'd7)) begin
                  cv_d    = 1'b1;
                  last_d  = cmd;
                  armed_d = (cmd == CMD_RSTEN);
                  state_d = ST_IGNORE;
                  cnt_d   = '0;
                  ph_d    = 1'b0;
                  if (cmd == CMD_RSTEN) begin
                  end else if (cmd == CMD_RST) begin
                     if (armed_q) begin
                        qpi_d = 1'b0;
                        err_d = 1'b0;
                     end
                  end else if (cmd == CMD_QPI_EN && !qpi_q) qpi_d = 1'b1;
                  else if (cmd == CMD_QPI_EX && qpi_q) qpi_d = 1'b0;
                  else if ((cmd == CMD_QWRITE || cmd == CMD_QREAD) && qpi_q) begin
                     state_d = ST_ADDR;
                     wr_d    = (cmd == CMD_QWRITE);
                  end else err_d = 1'b1;
               end
            end
            ST_ADDR: if (sclk_rise) begin
               addr_d = {addr_q[ADDR_W-5:0], mem_sio};
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == 8'd5) begin
                  cnt_d   = '0;
                  state_d = wr_q ? ST_WDATA : (WAIT_CYCLES == 0 ? ST_RDATA : ST_WAIT);
               end
            end
            ST_WAIT: if (sclk_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(WAIT_CYCLES - 1)) state_d = ST_RDATA;
            end
            ST_WDATA: if (sclk_rise) begin
               hi_d   = ph_q ? hi_q : mem_sio;
               we     = ph_q;
               addr_d = ph_q ? addr_q + 1'b1 : addr_q;
               ph_d   = ~ph_q;
            end
            ST_RDATA: if (sclk_fall) begin
               oe_d   = 1'b1;
               dout_d = ph_q ? rd_byte[3:0] : rd_byte[7:4];
               addr_d = ph_q ? addr_q + 1'b1 : addr_q;
               ph_d   = ~ph_q;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         hi_q    <= '0;
         dout_q  <= '0;
         wr_q    <= 1'b0;
         ph_q    <= 1'b0;
         oe_q    <= 1'b0;
         qpi_q   <= 1'b0;
         cv_q    <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         dout_q  <= dout_d;
         wr_q    <= wr_d;
         ph_q    <= ph_d;
         oe_q    <= oe_d;
         qpi_q   <= qpi_d;
         cv_q    <= cv_d;
         err_q   <= err_d;
         armed_q <= armed_d;
      end
   end
   // Array is deliberately not reset so it can map onto distributed RAM.
   always_ff @(posedge clk) if (we && !rst) mem[addr_q[ADDR_BITS-1:0]] <= {hi_q, mem_sio};
   assign mem_sio   = oe_q ? dout_q : 4'bzzzz;
   assign qpi_mode  = qpi_q;
   assign cmd_valid = cv_q;
   assign last_cmd  = last_q;
   assign error     = err_q;
endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: directed controller-side stimulus with a read-data scoreboard.
module tb_psram_responder;
   import psram_pkg::*;
   logic       clk = 1'b0, rst = 1'b1, mem_ce = 1'b1, mem_clk = 1'b0;
   logic       tb_oe = 1'b0;
   logic [3:0] tb_dout = '0;
   wire  [3:0] mem_sio;
   logic       qpi_mode, cmd_valid, error;
   logic [7:0] last_cmd;
   int         tests = 0, fails = 0, pulses = 0;
   logic [7:0] model [256];
   logic [3:0] exp_q [$];

   assign mem_sio = tb_oe ? tb_dout : 4'bzzzz;
   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_valid) pulses <= pulses + 1;

   psram_responder dut (
      .clk(clk), .rst(rst), .mem_ce(mem_ce), .mem_clk(mem_clk), .mem_sio(mem_sio),
      .qpi_mode(qpi_mode), .cmd_valid(cmd_valid), .last_cmd(last_cmd), .error(error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      mem_clk = 1'b1;
      repeat (4) @(posedge clk);
      mem_clk = 1'b0;
      repeat (4) @(posedge clk);
   endtask
   task automatic nib(input logic [3:0] n);
      tb_oe   = 1'b1;
      tb_dout = n;
      tick();
   endtask
   task automatic frame_start();
      mem_ce = 1'b0;
      repeat (6) @(posedge clk);
   endtask
   task automatic frame_end();
      tb_oe  = 1'b0;
      mem_ce = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask
   task automatic spi_cmd(input logic [7:0] b);
      frame_start();
      for (int i = 7; i >= 0; i--) nib({3'b000, b[i]});
      frame_end();
   endtask
   task automatic qpi_cmd(input logic [7:0] b);
      frame_start();
      nib(b[7:4]);
      nib(b[3:0]);
      frame_end();
   endtask
   task automatic qhdr(input logic [7:0] op, input logic [23:0] a);
      nib(op[7:4]);
      nib(op[3:0]);
      for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
   endtask
   task automatic qwrite(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
      frame_start();
      qhdr(CMD_QWRITE, a);
      nib(b0[7:4]);
      nib(b0[3:0]);
      nib(b1[7:4]);
      nib(b1[3:0]);
      frame_end();
      model[a[7:0]]        = b0;
      model[a[7:0] + 8'd1] = b1;
   endtask
   task automatic qread(input logic [23:0] a, input int n);
      logic [7:0] b;
      frame_start();
      qhdr(CMD_QREAD, a);
      tb_oe = 1'b0;
      for (int j = 0; j < n; j++) begin
         b = model[a[7:0] + 8'(j)];
         exp_q.push_back(b[7:4]);
         exp_q.push_back(b[3:0]);
      end
      repeat (5) tick();
      while (exp_q.size() > 0) begin
         tick();
         #1;
         chk("rd_nibble", mem_sio, exp_q.pop_front());
      end
      frame_end();
      chk("rd_oe_off", dut.oe_q, 0);
   endtask

   initial begin
      repeat (4) @(posedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_qpi", qpi_mode, 0);
      chk("rst_cv", cmd_valid, 0);
      chk("rst_last", last_cmd, 8'h00);
      chk("rst_err", error, 0);
      chk("rst_oe", dut.oe_q, 0);
      chk("rst_state", dut.state_q, ST_IDLE);
      spi_cmd(CMD_RSTEN);
      chk("rsten_pulse", pulses, 1);
      chk("rsten_last", last_cmd, 8'h66);
      spi_cmd(CMD_RST);
      chk("rst_pulses", pulses, 2);
      chk("rst_last99", last_cmd, 8'h99);
      chk("rst_qpi0", qpi_mode, 0);
      chk("rst_err0", error, 0);
      spi_cmd(CMD_QPI_EN);
      chk("qpi_en", qpi_mode, 1);
      chk("qpi_en_last", last_cmd, 8'h35);
      qpi_cmd(CMD_RST);
      chk("rst_unarmed_qpi", qpi_mode, 1);
      chk("rst_unarmed_err", error, 0);
      chk("rst_unarmed_last", last_cmd, 8'h99);
      qwrite(24'h000010, 8'hA5, 8'h3C);
      qread(24'h000010, 2);
      qwrite(24'h0000FF, 8'h11, 8'h22);
      qread(24'h0000FF, 2);
      frame_start();
      nib(4'h3);
      nib(4'h8);
      repeat (3) nib(4'h0);
      frame_end();
      chk("abort_state", dut.state_q, ST_IDLE);
      chk("abort_err", error, 0);
      frame_start();
      qhdr(CMD_QWRITE, 24'h000010);
      nib(4'hF);
      frame_end();
      qpi_cmd(8'h07);
      chk("bad_err", error, 1);
      chk("bad_last", last_cmd, 8'h07);
      chk("bad_qpi", qpi_mode, 1);
      qread(24'h000010, 1);
      chk("err_sticky", error, 1);
      qpi_cmd(CMD_RSTEN);
      chk("armed_err_held", error, 1);
      qpi_cmd(CMD_RST);
      chk("clr_err", error, 0);
      chk("clr_qpi", qpi_mode, 0);
      chk("idle_cv", cmd_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
